// File: rtl/regfile_rename_pkg.sv
// rtl/regfile_rename_pkg.sv - shared constants for the renaming register file
package regfile_rename_pkg;

    localparam int NAME_W = 5;
    localparam logic [NAME_W-1:0] X0 = '0;

endpackage

// File: rtl/regfile_rename_rf_read_port.sv
// rtl/regfile_rename_rf_read_port.sv - operand resolution mux and registered dispatch output
module rf_read_port
    import regfile_rename_pkg::*;
#(
    parameter int NICK_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              req_en,
    input  logic [NAME_W-1:0] req_regnm,
    input  logic [NICK_W-1:0] tag_nick,
    input  logic [DATA_W-1:0] reg_dt,
    input  logic              cmt_en,
    input  logic [NAME_W-1:0] cmt_regnm,
    input  logic [DATA_W-1:0] cmt_dt,
    input  logic [NICK_W-1:0] cmt_nick,
    output logic              out_en,
    output logic              out_rdy,
    output logic [DATA_W-1:0] out_dt,
    output logic [NICK_W-1:0] out_nick
);

    logic              res_rdy;
    logic [DATA_W-1:0] res_dt;
    logic [NICK_W-1:0] res_nick;
    logic              take;

    assign take = req_en && !iclr;

    // Lookup uses pre-update state; a matching commit is forwarded directly.
    always_comb begin
        res_rdy  = 1'b1;
        res_dt   = '0;
        res_nick = '0;
        if (req_regnm == X0) begin
            res_rdy = 1'b1;
        end else if (cmt_en && cmt_regnm == req_regnm && cmt_nick == tag_nick) begin
            res_dt = cmt_dt;
        end else if (tag_nick == '0) begin
            res_dt = reg_dt;
        end else begin
            res_rdy  = 1'b0;
            res_nick = tag_nick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en   <= 1'b0;
            out_rdy  <= 1'b0;
            out_dt   <= '0;
            out_nick <= '0;
        end else if (rdy) begin
            out_en   <= take;
            out_rdy  <= take ? res_rdy  : 1'b0;
            out_dt   <= take ? res_dt   : '0;
            out_nick <= take ? res_nick : '0;
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with per-register rename tags
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int NICK_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iROB_nick_en,
    input  logic [NICK_W-1:0] iROB_nick,
    input  logic [NAME_W-1:0] iROB_nick_regnm,
    input  logic              iRF_en,
    input  logic [NAME_W-1:0] iRF_rd_regnm,
    input  logic [DATA_W-1:0] iRF_rd_dt,
    input  logic [NICK_W-1:0] iRF_rd_nick,
    input  logic              iID_rs1_en,
    input  logic              iID_rs2_en,
    input  logic [NAME_W-1:0] iID_rs1_regnm,
    input  logic [NAME_W-1:0] iID_rs2_regnm,
    output logic              oDP_rs1_en,
    output logic              oDP_rs2_en,
    output logic              oDP_rs1_rdy,
    output logic              oDP_rs2_rdy,
    output logic [DATA_W-1:0] oDP_rs1_dt,
    output logic [DATA_W-1:0] oDP_rs2_dt,
    output logic [NICK_W-1:0] oDP_rs1_nick,
    output logic [NICK_W-1:0] oDP_rs2_nick
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [NICK_W-1:0] tags [REG_NUM];

    logic commit_hit;
    logic rename_hit;

    assign commit_hit = iRF_en && iRF_rd_regnm != X0;
    assign rename_hit = iROB_nick_en && iROB_nick_regnm != X0 && !iclr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
        end else if (rdy) begin
            if (commit_hit) begin
                regs[iRF_rd_regnm] <= iRF_rd_dt;
            end
            // Flush beats rename beats commit tag-clear; a stale commit never clears a newer tag.
            for (int i = 1; i < REG_NUM; i++) begin
                if (iclr) begin
                    tags[i] <= '0;
                end else if (rename_hit && iROB_nick_regnm == i[NAME_W-1:0]) begin
                    tags[i] <= iROB_nick;
                end else if (commit_hit && iRF_rd_regnm == i[NAME_W-1:0]
                             && tags[i] == iRF_rd_nick) begin
                    tags[i] <= '0;
                end
            end
        end
    end

    rf_read_port #(.NICK_W(NICK_W), .DATA_W(DATA_W)) u_rs1 (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .iclr      (iclr),
        .req_en    (iID_rs1_en),
        .req_regnm (iID_rs1_regnm),
        .tag_nick  (tags[iID_rs1_regnm]),
        .reg_dt    (regs[iID_rs1_regnm]),
        .cmt_en    (commit_hit),
        .cmt_regnm (iRF_rd_regnm),
        .cmt_dt    (iRF_rd_dt),
        .cmt_nick  (iRF_rd_nick),
        .out_en    (oDP_rs1_en),
        .out_rdy   (oDP_rs1_rdy),
        .out_dt    (oDP_rs1_dt),
        .out_nick  (oDP_rs1_nick)
    );

    rf_read_port #(.NICK_W(NICK_W), .DATA_W(DATA_W)) u_rs2 (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .iclr      (iclr),
        .req_en    (iID_rs2_en),
        .req_regnm (iID_rs2_regnm),
        .tag_nick  (tags[iID_rs2_regnm]),
        .reg_dt    (regs[iID_rs2_regnm]),
        .cmt_en    (commit_hit),
        .cmt_regnm (iRF_rd_regnm),
        .cmt_dt    (iRF_rd_dt),
        .cmt_nick  (iRF_rd_nick),
        .out_en    (oDP_rs2_en),
        .out_rdy   (oDP_rs2_rdy),
        .out_dt    (oDP_rs2_dt),
        .out_nick  (oDP_rs2_nick)
    );

endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - scoreboard bench for regfile_rename
module tb_regfile_rename;

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic [31:0] dt;
        logic [4:0]  nick;
    } port_t;

    logic        clk = 1'b0;
    logic        rst, rdy, iclr;
    logic        iROB_nick_en;
    logic [4:0]  iROB_nick, iROB_nick_regnm;
    logic        iRF_en;
    logic [4:0]  iRF_rd_regnm, iRF_rd_nick;
    logic [31:0] iRF_rd_dt;
    logic        iID_rs1_en, iID_rs2_en;
    logic [4:0]  iID_rs1_regnm, iID_rs2_regnm;
    logic        oDP_rs1_en, oDP_rs2_en, oDP_rs1_rdy, oDP_rs2_rdy;
    logic [31:0] oDP_rs1_dt, oDP_rs2_dt;
    logic [4:0]  oDP_rs1_nick, oDP_rs2_nick;

    logic [31:0] mreg [32];
    logic [4:0]  mtag [32];
    port_t       last1, last2;
    port_t       q1 [$];
    port_t       q2 [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    regfile_rename dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
        .iROB_nick_en(iROB_nick_en), .iROB_nick(iROB_nick), .iROB_nick_regnm(iROB_nick_regnm),
        .iRF_en(iRF_en), .iRF_rd_regnm(iRF_rd_regnm), .iRF_rd_dt(iRF_rd_dt), .iRF_rd_nick(iRF_rd_nick),
        .iID_rs1_en(iID_rs1_en), .iID_rs2_en(iID_rs2_en),
        .iID_rs1_regnm(iID_rs1_regnm), .iID_rs2_regnm(iID_rs2_regnm),
        .oDP_rs1_en(oDP_rs1_en), .oDP_rs2_en(oDP_rs2_en),
        .oDP_rs1_rdy(oDP_rs1_rdy), .oDP_rs2_rdy(oDP_rs2_rdy),
        .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs2_dt(oDP_rs2_dt),
        .oDP_rs1_nick(oDP_rs1_nick), .oDP_rs2_nick(oDP_rs2_nick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic port_t resolve(input logic en, input logic [4:0] r);
        port_t p;
        p = '0;
        if (!en || iclr) return p;
        p.en = 1'b1;
        if (r == 5'd0) begin
            p.rdy = 1'b1;
        end else if (iRF_en && iRF_rd_regnm == r && iRF_rd_nick == mtag[r]) begin
            p.rdy = 1'b1;
            p.dt  = iRF_rd_dt;
        end else if (mtag[r] == 5'd0) begin
            p.rdy = 1'b1;
            p.dt  = mreg[r];
        end else begin
            p.nick = mtag[r];
        end
        return p;
    endfunction

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; iclr = 1'b0;
        iROB_nick_en = 1'b0; iROB_nick = '0; iROB_nick_regnm = '0;
        iRF_en = 1'b0; iRF_rd_regnm = '0; iRF_rd_dt = '0; iRF_rd_nick = '0;
        iID_rs1_en = 1'b0; iID_rs2_en = 1'b0; iID_rs1_regnm = '0; iID_rs2_regnm = '0;
    endtask

    // Inputs are set at a falling edge; expectations are pushed, model updated,
    // then the result is popped and compared at the next falling edge.
    task automatic cyc(input string tag);
        port_t e1, e2, g1, g2;
        if (rst) begin
            e1 = '0; e2 = '0;
            for (int i = 0; i < 32; i++) begin mreg[i] = '0; mtag[i] = '0; end
        end else if (!rdy) begin
            e1 = last1; e2 = last2;
        end else begin
            e1 = resolve(iID_rs1_en, iID_rs1_regnm);
            e2 = resolve(iID_rs2_en, iID_rs2_regnm);
            if (iRF_en && iRF_rd_regnm != 0) begin
                mreg[iRF_rd_regnm] = iRF_rd_dt;
                if (!iclr && mtag[iRF_rd_regnm] == iRF_rd_nick) mtag[iRF_rd_regnm] = '0;
            end
            if (iclr) begin
                for (int i = 0; i < 32; i++) mtag[i] = '0;
            end else if (iROB_nick_en && iROB_nick_regnm != 0) begin
                mtag[iROB_nick_regnm] = iROB_nick;
            end
        end
        last1 = e1; last2 = e2;
        q1.push_back(e1);
        q2.push_back(e2);
        @(negedge clk);
        g1 = {oDP_rs1_en, oDP_rs1_rdy, oDP_rs1_dt, oDP_rs1_nick};
        g2 = {oDP_rs2_en, oDP_rs2_rdy, oDP_rs2_dt, oDP_rs2_nick};
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        check({tag, ".rs1_en"},   32'(g1.en),   32'(e1.en));
        check({tag, ".rs1_rdy"},  32'(g1.rdy),  32'(e1.rdy));
        check({tag, ".rs1_dt"},   g1.dt,        e1.dt);
        check({tag, ".rs1_nick"}, 32'(g1.nick), 32'(e1.nick));
        check({tag, ".rs2_en"},   32'(g2.en),   32'(e2.en));
        check({tag, ".rs2_rdy"},  32'(g2.rdy),  32'(e2.rdy));
        check({tag, ".rs2_dt"},   g2.dt,        e2.dt);
        check({tag, ".rs2_nick"}, 32'(g2.nick), 32'(e2.nick));
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        iID_rs1_en = 1'b1; iID_rs1_regnm = a;
        iID_rs2_en = 1'b1; iID_rs2_regnm = b;
    endtask

    task automatic ren(input logic [4:0] r, input logic [4:0] n);
        iROB_nick_en = 1'b1; iROB_nick_regnm = r; iROB_nick = n;
    endtask

    task automatic cmt(input logic [4:0] r, input logic [4:0] n, input logic [31:0] d);
        iRF_en = 1'b1; iRF_rd_regnm = r; iRF_rd_nick = n; iRF_rd_dt = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        last1 = '0; last2 = '0;
        @(negedge clk);
        cyc("reset0");
        rst = 1'b1; rd(5, 5); cyc("reset1");

        idle(); rd(5, 5); cyc("rd_x5");
        idle(); ren(3, 7); cyc("ren3");
        idle(); rd(3, 3); cyc("rd_x3_wait7");
        idle(); cmt(3, 7, 32'hDEADBEEF); cyc("cmt3");
        idle(); rd(3, 3); cyc("rd_x3_beef");

        idle(); ren(3, 7); cyc("ren3_7");
        idle(); ren(3, 9); cyc("ren3_9");
        idle(); cmt(3, 7, 32'h11); cyc("stale_cmt");
        idle(); rd(3, 3); cyc("rd_x3_wait9");
        idle(); cmt(3, 9, 32'h22); cyc("cmt3_9");
        idle(); rd(3, 3); cyc("rd_x3_22");

        idle(); ren(4, 4); cyc("ren4");
        idle(); rd(4, 3); cmt(4, 4, 32'h55); cyc("bypass_x4");
        idle(); rd(4, 4); ren(4, 6); cyc("rd_before_ren");
        idle(); rd(4, 4); cyc("rd_x4_wait6");

        idle(); cmt(2, 0, 32'h77); cyc("cmt2");
        idle(); ren(1, 3); cyc("ren1");
        idle(); ren(2, 4); cyc("ren2");
        idle(); iclr = 1'b1; cmt(1, 3, 32'hA5); rd(1, 2); ren(5, 8); cyc("clr");
        idle(); rd(1, 2); cyc("after_clr");
        idle(); rd(5, 4); cyc("no_tags");

        idle(); cmt(0, 0, 32'h1234); ren(0, 5); cyc("x0_wr");
        idle(); rd(0, 0); cyc("rd_x0");

        idle(); rd(3, 4); cyc("pre_hold");
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 1'b0; ren(3, 12); rd(4, 3); cmt(3, 0, 32'h99); cyc("hold");
        end
        idle(); rd(3, 4); cyc("post_hold");

        for (int i = 0; i < 400; i++) begin
            logic [4:0] r;
            idle();
            rdy  = ($urandom % 8) != 0;
            rst  = ($urandom % 120) == 0;
            iclr = ($urandom % 25) == 0;
            if ($urandom % 2) ren(5'($urandom % 8), 5'($urandom_range(1, 31)));
            if ($urandom % 2) begin
                r = 5'($urandom % 8);
                cmt(r, ($urandom % 3) != 0 ? mtag[r] : 5'($urandom % 32), $urandom);
            end
            iID_rs1_en = $urandom % 4 != 0; iID_rs1_regnm = 5'($urandom % 8);
            iID_rs2_en = $urandom % 4 != 0; iID_rs2_regnm = 5'($urandom % 8);
            cyc("rand");
        end

        check("sb_drained", 32'(q1.size() + q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
